// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential PC generator feeding a small circular queue.
// Branch/jump redirects flush the queue and restart fetching at the target.
module instr_fetch_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
   parameter int                    DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] instr_addr,
   input  logic [DATA_WIDTH-1:0] instr,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_instr,
   output logic [ADDR_WIDTH-1:0] out_pc
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]         DEPTH_C    = CW'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] RESET_PC_A = {RESET_PC[ADDR_WIDTH-1:2], 2'b00};

   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [ADDR_WIDTH-1:0] pc_mem_q    [DEPTH];
   logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];
   logic                  push, pop;

   assign instr_addr = fetch_pc_q;
   assign out_valid  = (count_q != '0);
   assign out_instr  = instr_mem_q[rd_ptr_q];
   assign out_pc     = pc_mem_q[rd_ptr_q];
   assign pop        = out_valid & out_ready;
   // A full queue still accepts a fetch when the head leaves in the same cycle.
   assign push       = ~redirect_valid & ((count_q < DEPTH_C) | pop);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (redirect_valid) begin
         // Any coincident pop is consumed, then flushed along with the rest.
         fetch_pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            wr_ptr_d   = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC_A;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         if (push) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            instr_mem_q[wr_ptr_q] <= instr;
         end
      end
   end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 SHALL have parameter DEPTH, default 2, fetch-queue entries (power of two, >=2).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port instr_addr  output  ADDR_WIDTH  byte address to instruction memory.
REQ-008 SHALL have port instr  input  DATA_WIDTH  word returned combinationally, same cycle, for instr_addr.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-010 SHALL have port redirect_pc  input  ADDR_WIDTH  redirect target byte address.
REQ-011 SHALL have port out_valid  output  1  queue head holds a valid instruction.
REQ-012 SHALL have port out_ready  input  1  consumer accepts head this cycle.
REQ-013 SHALL have port out_instr  output  DATA_WIDTH  instruction at queue head.
REQ-014 SHALL have port out_pc  output  ADDR_WIDTH  byte address of out_instr.

Function
REQ-015 SHALL hold a fetch_pc register and drive instr_addr = fetch_pc combinationally; fetch_pc[1:0] always 2'b00.
REQ-016 SHALL hold a DEPTH-entry circular queue of {pc, instr} with read/write pointers and a count 0..DEPTH.
REQ-017 SHALL define pop = out_valid & out_ready; out_valid = (count != 0).
REQ-018 SHALL define push = ~redirect_valid & ((count < DEPTH) | pop); on push write {fetch_pc, instr} at write pointer and advance fetch_pc by 4.
REQ-019 SHALL drive out_instr/out_pc from the queue head register, never combinationally from instr.
REQ-020 SHALL allow push and pop in the same cycle, including when full (count unchanged).
REQ-021 SHALL ignore pop when count == 0 (no underflow) and block push when full without pop (no overflow, fetch_pc holds).
REQ-022 SHALL wrap queue pointers modulo DEPTH.
REQ-023 SHALL wrap fetch_pc modulo 2^ADDR_WIDTH (32'hFFFF_FFFC + 4 = 0).
REQ-024 SHALL, on redirect_valid, set fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}, clear count and pointers, and perform no push that cycle.
REQ-025 SHALL treat a pop coinciding with redirect_valid as completed (head consumed), then flushed with the rest.
REQ-026 SHALL produce first out_valid one cycle after redirect or reset release (fetch at target in cycle N, visible at out_* in N+1).
REQ-027 SHALL sustain one instruction per cycle when out_ready is held high.

Reset
REQ-028 SHALL, while reset is high and independent of clk, force fetch_pc = RESET_PC, count = 0, pointers = 0, out_valid = 0, out_instr = 0, out_pc = 0.
REQ-029 SHALL abort any in-flight queue contents on reset assertion mid-operation; nothing is retained.
REQ-030 SHALL resume fetching at RESET_PC on the first rising clk edge after reset deasserts.

Verification
REQ-031 Reset release, out_ready=1, memory word[k]=k -> out_pc 0,4,8,12 on consecutive cycles from cycle 1, out_instr 0,1,2,3.
REQ-032 out_ready=0 for 5 cycles after reset -> count saturates at 2, instr_addr holds 0x8, out_pc holds 0x0; out_ready=1 -> out_pc 0x0,0x4,0x8 back-to-back.
REQ-033 Queue full, redirect_valid=1 with redirect_pc=0x103 -> next cycle out_valid=0, instr_addr=0x100; following cycle out_valid=1, out_pc=0x100.
REQ-034 Redirect to 0xFFFF_FFF8, out_ready=1 -> out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-035 Reset asserted asynchronously mid-stream between clock edges -> out_valid=0 and instr_addr=RESET_PC immediately, before next edge.
REQ-036 Redirect and pop in same cycle with head pc 0x20 -> 0x20 counted consumed once, no later out_pc 0x24 before target.
